// File: rtl/boot_pkg.sv
// Shared state encodings, counter widths and default timing constants for the boot sequencer.
package boot_pkg;

  localparam int unsigned STATE_W           = 3;
  localparam int unsigned CNT_W             = 8;
  localparam int unsigned DEF_STABLE_CYCLES = 8;
  localparam int unsigned DEF_LOAD_TIMEOUT  = 200;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF     = 3'd0,
    ST_QUALIFY = 3'd1,
    ST_LOAD    = 3'd2,
    ST_RUN     = 3'd3,
    ST_STOP    = 3'd4,
    ST_FAULT   = 3'd5
  } boot_state_e;

  // Registered control outputs driven towards memory/CPU.
  typedef struct packed {
    logic mem_rst_n;
    logic cpu_rst_n;
    logic load_start;
    logic boot_done;
  } boot_out_t;

  // Saturating increment: counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer with asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/boot_sequencer.sv
// Power-on boot sequencer: qualifies power-good, runs the ROM load, releases the CPU.
// Optional LOAD timeout into FAULT is compiled in with `define BOOT_SEQUENCER_TIMEOUT_EN.
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned LOAD_TIMEOUT  = DEF_LOAD_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       is_powered_on,
  input  logic       rom_load_done,
  output logic       mem_reset_n,
  output logic       cpu_reset_n,
  output logic       rom_load_start,
  output logic       boot_done,
  output logic       boot_fault,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_TIMEOUT);

  if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255 || LOAD_TIMEOUT < 1 || LOAD_TIMEOUT > 255)
  begin : g_bad_param
    $error("boot_sequencer: STABLE_CYCLES or LOAD_TIMEOUT out of range");
  end

  logic             w_pwr_sync;
  boot_state_e      r_state;
  boot_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_qual_cnt;
  logic [CNT_W-1:0] w_qual_cnt_nxt;
  logic [CNT_W-1:0] w_qual_inc;
  boot_out_t        r_out;
  boot_out_t        w_out_nxt;

  sync_2ff u_pwr_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .i_d   (is_powered_on),
    .o_q   (w_pwr_sync)
  );

  assign w_qual_inc = sat_inc(r_qual_cnt);

`ifdef BOOT_SEQUENCER_TIMEOUT_EN
  logic [CNT_W-1:0] r_load_cnt;
  logic [CNT_W-1:0] w_load_cnt_nxt;
  logic [CNT_W-1:0] w_load_inc;
  logic             r_fault;

  assign w_load_inc = sat_inc(r_load_cnt);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_OFF;
      r_qual_cnt <= '0;
      r_out      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_qual_cnt <= w_qual_cnt_nxt;
      r_out      <= w_out_nxt;
    end
  end

  // Next state; power loss always outranks load completion and timeout.
  always_comb begin
    w_state_nxt    = r_state;
    w_qual_cnt_nxt = '0;
    case (r_state)
      ST_OFF: begin
        if (w_pwr_sync) w_state_nxt = ST_QUALIFY;
      end
      ST_QUALIFY: begin
        if (!w_pwr_sync)               w_state_nxt = ST_OFF;
        else if (w_qual_inc == QUAL_LAST) w_state_nxt = ST_LOAD;
        else                           w_qual_cnt_nxt = w_qual_inc;
      end
      ST_LOAD: begin
        if (!w_pwr_sync)        w_state_nxt = ST_OFF;
        else if (rom_load_done) w_state_nxt = ST_RUN;
`ifdef BOOT_SEQUENCER_TIMEOUT_EN
        else if (w_load_inc == LOAD_LAST) w_state_nxt = ST_FAULT;
`endif
      end
      ST_RUN: begin
        if (!w_pwr_sync) w_state_nxt = ST_STOP;
      end
      ST_STOP:  w_state_nxt = ST_OFF;
      ST_FAULT: begin
        if (!w_pwr_sync) w_state_nxt = ST_OFF;
      end
      default:  w_state_nxt = ST_OFF;
    endcase
  end

  // Outputs decoded from the next state so they change together with the state register.
  always_comb begin
    w_out_nxt            = '0;
    w_out_nxt.load_start = (r_state == ST_QUALIFY) && (w_state_nxt == ST_LOAD);
    case (w_state_nxt)
      ST_LOAD, ST_STOP: w_out_nxt.mem_rst_n = 1'b1;
      ST_RUN: begin
        w_out_nxt.mem_rst_n = 1'b1;
        w_out_nxt.cpu_rst_n = 1'b1;
        w_out_nxt.boot_done = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef BOOT_SEQUENCER_TIMEOUT_EN
  always_comb begin
    w_load_cnt_nxt = '0;
    if (r_state == ST_LOAD && w_state_nxt == ST_LOAD) w_load_cnt_nxt = w_load_inc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_load_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_load_cnt <= w_load_cnt_nxt;
      r_fault    <= (w_state_nxt == ST_FAULT);
    end
  end

  assign boot_fault = r_fault;
`else
  assign boot_fault = 1'b0;
`endif

  assign mem_reset_n    = r_out.mem_rst_n;
  assign cpu_reset_n    = r_out.cpu_rst_n;
  assign rom_load_start = r_out.load_start;
  assign boot_done      = r_out.boot_done;
  assign state          = 3'(r_state);

endmodule

// File: doc/boot_sequencer.md
BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 Parameter STABLE_CYCLES, default 8: consecutive synchronized cycles is_powered_on SHALL stay high before boot proceeds (legal 2..255).
REQ-002 Parameter LOAD_TIMEOUT, default 200: maximum LOAD-state cycles before fault when the timeout feature is compiled in (legal 1..255).
REQ-003 clk  input  1  single system clock; all state on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 is_powered_on  input  1  power-good level from the power-on controller; asynchronous to clk.
REQ-006 rom_load_done  input  1  single-cycle pulse from the ROM loader: program image loaded.
REQ-007 mem_reset_n  output  1  active-low reset to memory and ROM loader.
REQ-008 cpu_reset_n  output  1  active-low reset to the CPU core.
REQ-009 rom_load_start  output  1  single-cycle pulse requesting the ROM load.
REQ-010 boot_done  output  1  high while the CPU is running.
REQ-011 boot_fault  output  1  high while in FAULT.
REQ-012 state  output  3  current state encoding, for debug.

Function
REQ-013 is_powered_on SHALL pass through a two-flop synchronizer; pwr_sync lags the input by exactly 2 clk edges.
REQ-014 States SHALL be OFF=0, QUALIFY=1, LOAD=2, RUN=3, STOP=4, FAULT=5; all outputs registered, no combinational input-to-output path.
REQ-015 OFF: mem_reset_n=0, cpu_reset_n=0, boot_done=0; pwr_sync=1 -> QUALIFY with qualify counter=0.
REQ-016 QUALIFY: counter increments each cycle pwr_sync=1; pwr_sync=0 -> OFF, counter cleared; counter reaching STABLE_CYCLES-1 -> LOAD.
REQ-017 On the QUALIFY->LOAD edge mem_reset_n SHALL go 1 and rom_load_start SHALL pulse high for exactly one cycle, the first LOAD cycle.
REQ-018 LOAD: rom_load_done=1 -> RUN; cpu_reset_n and boot_done go 1 on the first RUN cycle.
REQ-019 LOAD: pwr_sync=0 -> OFF, outranking a same-cycle rom_load_done; mem_reset_n returns to 0 on the next edge.
REQ-020 RUN: pwr_sync=0 -> STOP; cpu_reset_n=0 and boot_done=0 in STOP while mem_reset_n stays 1 for that one cycle; STOP -> OFF unconditionally.
REQ-021 rom_load_done SHALL be ignored in every state other than LOAD.
REQ-022 FAULT: both resets 0, boot_fault=1; exit only on pwr_sync=0 -> OFF, boot_fault cleared in OFF.
REQ-023 Counter widths SHALL be 8 bits, saturating, never wrapping.
REQ-024 Minimum latency pwr rise to cpu_reset_n=1 SHALL be 2 + STABLE_CYCLES + 1 + load cycles.

Reset
REQ-025 reset_n low SHALL immediately force state=OFF, synchronizer flops=0, counters=0, all outputs 0 (resets asserted), independent of clk.
REQ-026 reset_n low mid-LOAD or mid-RUN SHALL drop cpu_reset_n and mem_reset_n in the same instant; deassertion restarts from OFF.

Configuration
REQ-027 Macro BOOT_SEQUENCER_TIMEOUT_EN defined: a LOAD-cycle counter runs; reaching LOAD_TIMEOUT without rom_load_done -> FAULT.
REQ-028 Macro undefined: LOAD waits indefinitely, FAULT unreachable, boot_fault tied 0, timeout counter absent.

Structure
REQ-029 Shared package boot_pkg SHALL hold state encodings and the default STABLE_CYCLES/LOAD_TIMEOUT constants.
REQ-030 Synchronizer SHALL be a separate sub-module sync_2ff (1-bit, async active-low reset to 0), reusable elsewhere.

Verification
REQ-031 Power rises at cycle 10 and stays, rom_load_done at first LOAD cycle+5 -> rom_load_start single pulse at cycle 20, cpu_reset_n=1 and boot_done=1 at cycle 26.
REQ-032 Power glitch high 5 cycles then low (STABLE_CYCLES=8) -> state back to OFF, rom_load_start never pulses, mem_reset_n stays 0.
REQ-033 Power drops during RUN -> cpu_reset_n=0 one cycle before mem_reset_n=0; state sequence RUN,STOP,OFF.
REQ-034 Macro defined, LOAD_TIMEOUT=20, no rom_load_done -> FAULT after 20 LOAD cycles, boot_fault=1; power low -> OFF, boot_fault=0.
REQ-035 rom_load_done and power-loss in same LOAD cycle -> OFF, never RUN; reset_n pulsed low mid-RUN -> all outputs 0 asynchronously.
